// File: rtl/gsu_pkg.sv
// Shared GSU constants and types used by the instruction cache.
package gsu_pkg;

  localparam int GSU_CACHE_ADDR_W = 9;
  localparam int GSU_CACHE_LINE_W = 4;
  localparam int GSU_CACHE_LINES  = 32;
  localparam logic [7:0] OP_NOP   = 8'h01;

  typedef logic [GSU_CACHE_ADDR_W-1:0]                  gsu_cache_addr_t;
  typedef logic [GSU_CACHE_ADDR_W-GSU_CACHE_LINE_W-1:0] gsu_cache_line_t;

endpackage

// File: rtl/gsu_cache_valid.sv
// Per-line valid array for the GSU instruction cache with a registered lookup.
// Flush beats a set on the same edge; reset beats both.
module gsu_cache_valid #(
  parameter int LINES_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               set,
  input  logic [LINES_W-1:0] set_line,
  input  logic               flush,
  input  logic [LINES_W-1:0] lookup_line,
  output logic               hit
);

  localparam int LINES = 1 << LINES_W;

  logic [LINES-1:0] valid;
  logic [LINES-1:0] valid_next;

  // Next valid vector; the lookup reads this so a same-cycle set is visible.
  always_comb begin
    valid_next = valid;
    if (flush) begin
      valid_next = {LINES{1'b0}};
    end else if (set) begin
      valid_next[set_line] = 1'b1;
    end else begin
      valid_next = valid;
    end
  end

  // Valid array and registered lookup.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= {LINES{1'b0}};
      hit   <= 1'b0;
    end else begin
      valid <= valid_next;
      hit   <= valid_next[lookup_line];
    end
  end

endmodule

// File: rtl/gsu_cache_ram.sv
// GSU instruction cache: 512-byte single-port write-first RAM plus per-line valid bits.
// Reset clears the output registers and valid bits but leaves the byte contents alone.
module gsu_cache_ram
  import gsu_pkg::*;
#(
  parameter int ADDR_W = GSU_CACHE_ADDR_W,
  parameter int DATA_W = 8,
  parameter int LINE_W = GSU_CACHE_LINE_W
) (
  input  logic              clka,
  input  logic              rsta,
  input  logic [ADDR_W-1:0] addra,
  input  logic [DATA_W-1:0] dina,
  input  logic              wea,
  input  logic              flush,
  output logic [DATA_W-1:0] douta,
  output logic              dvalid
);

  localparam int DEPTH   = 1 << ADDR_W;
  localparam int LINES_W = ADDR_W - LINE_W;

  logic [DATA_W-1:0] mem [DEPTH] = '{default: {DATA_W{1'b0}}};
  logic              line_end;
  logic              do_write;

  assign line_end = (addra[LINE_W-1:0] == {LINE_W{1'b1}});
  assign do_write = wea & ~rsta;

  // Byte storage; kept free of reset so it maps onto block RAM.
  always_ff @(posedge clka) begin
    if (do_write) begin
      mem[addra] <= dina;
    end
  end

  // Registered read port, write-first.
  always_ff @(posedge clka) begin
    if (rsta) begin
      douta <= {DATA_W{1'b0}};
    end else if (wea) begin
      douta <= dina;
    end else begin
      douta <= mem[addra];
    end
  end

  gsu_cache_valid #(
    .LINES_W (LINES_W)
  ) u_valid (
    .clk         (clka),
    .rst         (rsta),
    .set         (wea & line_end),
    .set_line    (addra[ADDR_W-1:LINE_W]),
    .flush       (flush),
    .lookup_line (addra[ADDR_W-1:LINE_W]),
    .hit         (dvalid)
  );

endmodule

// File: tb/tb_gsu_cache_ram.sv
// Self-checking bench for gsu_cache_ram: directed scenarios plus random traffic
// checked against a byte-array / line-flag reference model.
module tb_gsu_cache_ram;

  logic       clka = 1'b0;
  logic       rsta = 1'b0;
  logic [8:0] addra = 9'd0;
  logic [7:0] dina = 8'd0;
  logic       wea = 1'b0;
  logic       flush = 1'b0;
  logic [7:0] douta;
  logic       dvalid;

  int n_cmp = 0;
  int n_err = 0;

  byte unsigned ref_mem [512];
  bit           ref_valid [32];

  gsu_cache_ram dut (
    .clka   (clka),
    .rsta   (rsta),
    .addra  (addra),
    .dina   (dina),
    .wea    (wea),
    .flush  (flush),
    .douta  (douta),
    .dvalid (dvalid)
  );

  always #5 clka = ~clka;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One access: update the model from the rules, clock the DUT, compare both outputs.
  task automatic cyc(input bit r, input int a, input bit we, input byte unsigned d, input bit fl,
                     input string tag);
    byte unsigned exp_d;
    bit           exp_v;
    if (r) begin
      exp_d = 8'd0;
      exp_v = 1'b0;
      for (int i = 0; i < 32; i++) ref_valid[i] = 1'b0;
    end else begin
      if (we) begin
        ref_mem[a] = d;
        exp_d = d;
      end else begin
        exp_d = ref_mem[a];
      end
      if (fl) begin
        for (int i = 0; i < 32; i++) ref_valid[i] = 1'b0;
      end else if (we && (a % 16 == 15)) begin
        ref_valid[a / 16] = 1'b1;
      end
      exp_v = ref_valid[a / 16];
    end
    rsta  = r;
    addra = a[8:0];
    wea   = we;
    dina  = d;
    flush = fl;
    @(posedge clka);
    #1;
    check({tag, ".douta"}, {24'd0, douta}, {24'd0, exp_d});
    check({tag, ".dvalid"}, {31'd0, dvalid}, {31'd0, exp_v});
  endtask

  initial begin
    for (int i = 0; i < 512; i++) ref_mem[i] = 8'd0;
    for (int i = 0; i < 32; i++) ref_valid[i] = 1'b0;

    // Reset then read
    cyc(1'b1, 0, 1'b0, 8'd0, 1'b0, "rst0");
    cyc(1'b1, 0, 1'b0, 8'd0, 1'b0, "rst1");
    cyc(1'b0, 0, 1'b0, 8'd0, 1'b0, "rd0");
    check("reset_douta", {24'd0, douta}, 32'h00);

    // Write-first and read latency
    cyc(1'b0, 9'h012, 1'b1, 8'hA5, 1'b0, "wr012");
    check("write_first", {24'd0, douta}, 32'hA5);
    cyc(1'b0, 9'h013, 1'b0, 8'd0, 1'b0, "rd013");
    check("rd013", {24'd0, douta}, 32'h00);
    cyc(1'b0, 9'h012, 1'b0, 8'd0, 1'b0, "rd012");
    check("rd012", {24'd0, douta}, 32'hA5);

    // Line validation
    for (int i = 9'h020; i <= 9'h02E; i++) cyc(1'b0, i, 1'b1, 8'(i + 3), 1'b0, "fill02x");
    cyc(1'b0, 9'h025, 1'b0, 8'd0, 1'b0, "rd025");
    check("partial_line_invalid", {31'd0, dvalid}, 32'd0);
    cyc(1'b0, 9'h02F, 1'b1, 8'h5A, 1'b0, "wr02F");
    check("line_end_same_cycle", {31'd0, dvalid}, 32'd1);
    cyc(1'b0, 9'h020, 1'b0, 8'd0, 1'b0, "rd020");
    check("line2_valid", {31'd0, dvalid}, 32'd1);
    cyc(1'b0, 9'h030, 1'b0, 8'd0, 1'b0, "rd030");
    check("line3_invalid", {31'd0, dvalid}, 32'd0);

    // Flush
    cyc(1'b0, 9'h00F, 1'b1, 8'hC3, 1'b0, "wr00F");
    cyc(1'b0, 9'h1FF, 1'b1, 8'h9E, 1'b0, "wr1FF");
    cyc(1'b0, 9'h1F0, 1'b0, 8'd0, 1'b0, "rd1F0");
    check("line31_valid", {31'd0, dvalid}, 32'd1);
    cyc(1'b0, 9'h100, 1'b0, 8'd0, 1'b1, "flush");
    cyc(1'b0, 9'h00F, 1'b0, 8'd0, 1'b0, "rd00F");
    check("flush_line0", {31'd0, dvalid}, 32'd0);
    check("flush_keeps_data", {24'd0, douta}, 32'hC3);
    cyc(1'b0, 9'h1FF, 1'b0, 8'd0, 1'b0, "rd1FF");
    check("flush_line31", {31'd0, dvalid}, 32'd0);

    // Flush together with a line-end write
    cyc(1'b0, 9'h04F, 1'b1, 8'h3C, 1'b1, "flushwr");
    check("flushwr_valid", {31'd0, dvalid}, 32'd0);
    cyc(1'b0, 9'h04F, 1'b0, 8'd0, 1'b0, "rd04F");
    check("flushwr_data", {24'd0, douta}, 32'h3C);
    check("flushwr_line", {31'd0, dvalid}, 32'd0);

    // Reset mid-operation blocks the write and clears valid bits
    cyc(1'b0, 9'h02F, 1'b1, 8'h11, 1'b0, "revalidate");
    cyc(1'b1, 9'h060, 1'b1, 8'h77, 1'b0, "rstwr");
    check("rstwr_douta", {24'd0, douta}, 32'h00);
    cyc(1'b0, 9'h060, 1'b0, 8'd0, 1'b0, "rd060");
    check("rst_blocks_write", {24'd0, douta}, 32'h00);
    cyc(1'b0, 9'h02F, 1'b0, 8'd0, 1'b0, "rd02F");
    check("rst_clears_valid", {31'd0, dvalid}, 32'd0);
    check("rst_keeps_data", {24'd0, douta}, 32'h11);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      int  a;
      bit  r;
      bit  we;
      bit  fl;
      a  = $urandom_range(0, 511);
      if ($urandom_range(0, 2) == 0) a = a | 15;
      r  = ($urandom_range(0, 99) == 0);
      we = ($urandom_range(0, 1) == 1);
      fl = ($urandom_range(0, 29) == 0);
      cyc(r, a, we, 8'($urandom), fl, "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
